vga_sync_decoder: RTL

Receive-side counterpart of the VGA timing generator. It samples an incoming active-low hSync/vSync pair on the pixel clock and rebuilds row, column and displayActive from the sync edges alone. It also checks line length, sync width and frame length, and reports lock and a saturating error count. It is used for loopback self-test of the timing generator and as a front end for capturing external 640x480@60 video into the frame pipeline.

---
 rtl/vga_sync_decoder_if.sv | 21 ++
 rtl/vga_sync_decoder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder_if.sv
// Recovered-video bundle: incoming sync pair plus the rebuilt timing and lock status.
interface vga_sync_decoder_if;
    logic       hSync;
    logic       vSync;
    logic [8:0] row;
    logic [9:0] column;
    logic       displayActive;
    logic       locked;
    logic       frameStart;
    logic [7:0] errCount;

    modport master (
        output hSync, vSync,
        input  row, column, displayActive, locked, frameStart, errCount
    );

    modport slave (
        input  hSync, vSync,
        output row, column, displayActive, locked, frameStart, errCount
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Rebuilds row/column/displayActive from an active-low hSync/vSync pair and tracks timing lock.
// state  | meaning
// SEARCH | waiting for a frame boundary, errors ignored
// CHECK  | counting clean frames toward lock
// LOCKED | timing trusted, displayActive enabled
module vga_sync_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              clkDiv,
    input  logic              rst,
    vga_sync_decoder_if.slave vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int H_END   = H_START + H_ACTIVE;
    localparam int V_START = V_SYNC + V_BP;
    localparam int V_END   = V_START + V_ACTIVE;
    localparam logic [9:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} lock_state_t;

    lock_state_t state, state_nxt;
    logic [3:0]  good_frames, good_nxt;
    logic        count_err;

    logic [2:0]  hs_sync, vs_sync;
    logic [9:0]  h_count, v_count;
    logic        v_pending;
    logic        seen_hfall, seen_hrise, seen_vreset;

    logic h_fall, h_rise, v_fall, v_reset;
    logic line_err, width_err, frame_err, tout_err, err_any;
    logic h_win, v_win, win;

    // bit 2 is the oldest sample; edges are judged between the two oldest flops
    assign h_fall  = hs_sync[2] & ~hs_sync[1];
    assign h_rise  = ~hs_sync[2] & hs_sync[1];
    assign v_fall  = vs_sync[2] & ~vs_sync[1];
    assign v_reset = h_fall & (v_pending | v_fall);

    assign line_err  = h_fall & seen_hfall & (h_count != 10'(H_TOTAL - 1));
    assign width_err = h_rise & seen_hrise & (h_count != 10'(H_SYNC - 1));
    assign frame_err = v_reset & seen_vreset & (v_count != 10'(V_TOTAL - 1));
    assign tout_err  = ~h_fall & (h_count == CNT_MAX - 10'd1);
    assign err_any   = line_err | width_err | frame_err | tout_err;

    assign h_win = (h_count >= 10'(H_START)) && (h_count < 10'(H_END));
    assign v_win = (v_count >= 10'(V_START)) && (v_count < 10'(V_END));
    assign win   = h_win & v_win;

    assign vid.locked = (state == LOCKED);

    always_comb begin
        state_nxt = state;
        good_nxt  = good_frames;
        count_err = 1'b0;
        case (state)
            SEARCH: begin
                if (v_reset) begin
                    state_nxt = CHECK;
                    good_nxt  = 4'd0;
                end
            end
            CHECK: begin
                if (err_any) begin
                    state_nxt = SEARCH;
                    count_err = 1'b1;
                end else if (v_reset) begin
                    good_nxt = good_frames + 4'd1;
                    if (good_nxt == 4'(LOCK_FRAMES)) begin
                        state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (err_any) begin
                    state_nxt = SEARCH;
                    count_err = 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clkDiv) begin
        if (rst) begin
            state       <= SEARCH;
            good_frames <= 4'd0;
        end else begin
            state       <= state_nxt;
            good_frames <= good_nxt;
        end
    end

    always_ff @(posedge clkDiv) begin
        if (rst) begin
            hs_sync           <= 3'b111;
            vs_sync           <= 3'b111;
            h_count           <= CNT_MAX;
            v_count           <= CNT_MAX;
            v_pending         <= 1'b0;
            seen_hfall        <= 1'b0;
            seen_hrise        <= 1'b0;
            seen_vreset       <= 1'b0;
            vid.row           <= 9'd0;
            vid.column        <= 10'd0;
            vid.displayActive <= 1'b0;
            vid.frameStart    <= 1'b0;
            vid.errCount      <= 8'd0;
        end else begin
            hs_sync <= {hs_sync[1:0], vid.hSync};
            vs_sync <= {vs_sync[1:0], vid.vSync};

            if (h_fall) begin
                h_count <= 10'd0;
            end else if (h_count != CNT_MAX) begin
                h_count <= h_count + 10'd1;
            end

            if (h_fall) begin
                if (v_reset) begin
                    v_count <= 10'd0;
                end else if (v_count != CNT_MAX) begin
                    v_count <= v_count + 10'd1;
                end
            end

            // a vSync fall arriving with the line start is consumed immediately
            if (v_reset) begin
                v_pending <= 1'b0;
            end else if (v_fall) begin
                v_pending <= 1'b1;
            end

            if (h_fall)  seen_hfall  <= 1'b1;
            if (h_rise)  seen_hrise  <= 1'b1;
            if (v_reset) seen_vreset <= 1'b1;

            vid.column        <= win ? (h_count - 10'(H_START)) : 10'd0;
            vid.row           <= win ? 9'(v_count - 10'(V_START)) : 9'd0;
            vid.displayActive <= win & (state_nxt == LOCKED);
            vid.frameStart    <= v_reset;

            if (count_err && (vid.errCount != 8'hFF)) begin
                vid.errCount <= vid.errCount + 8'd1;
            end
        end
    end

endmodule
